// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_arb_pkg;

  // One buffered MDU writeback: destination register plus result.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // Writes to x0 are architecturally dropped.
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/wb_arb_fifo.sv
// In-order buffer of MDU results waiting for the register-file write port.
// Latency: a push is visible at head on the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  wb_entry_t                    din,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage: written at the tail, no reset needed since count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results.
// Latency: a grant in cycle N drives rf_* in cycle N+1; MDU results wait in an in-order buffer.
// Backpressure: mdu_ready drops when the buffer is full; pipe_stall holds WB while an MDU write wins.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic        pipe_regwrite,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_result,
  output logic        pipe_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_result,
  output logic        mdu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] WAIT_LIMIT = SW'(MAX_WAIT);

  logic            pipe_req;
  logic            mdu_grant;
  logic            pipe_grant;
  logic            push;
  wb_entry_t       push_entry;
  wb_entry_t       head;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  assign pipe_req   = pipe_valid & pipe_regwrite & (pipe_rd != REG_X0);
  // No pop bypass: a full buffer refuses even when it drains this cycle.
  assign mdu_ready  = (count < CW'(DEPTH)) & ~reset;
  // x0 results are accepted from the MDU but never stored.
  assign push       = mdu_valid & mdu_ready & (mdu_rd != REG_X0);
  assign push_entry = '{rd: mdu_rd, data: mdu_result};
  assign mdu_grant  = ~empty & (~pipe_req | full | (starve_cnt == WAIT_LIMIT));
  assign pipe_grant = pipe_req & ~mdu_grant;
  assign pipe_stall = pipe_req & mdu_grant & ~reset;

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (mdu_grant),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Age of the buffer head while it is being denied the port.
  always_ff @(posedge clk) begin
    if (reset || mdu_grant || empty) starve_cnt <= '0;
    else if (starve_cnt != WAIT_LIMIT) starve_cnt <= starve_cnt + SW'(1);
  end

  // Registered write port; idle cycles drive all-zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (mdu_grant) begin
      rf_we <= 1'b1;
      rf_rd <= head.rd;
      rf_wd <= head.data;
    end else if (pipe_grant) begin
      rf_we <= 1'b1;
      rf_rd <= pipe_rd;
      rf_wd <= pipe_result;
    end else begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with DEPTH=2, MAX_WAIT=4.
// Latency: inputs change 1 time unit after each rising edge, outputs sampled before the next.
// Backpressure: exercised via a filled buffer and pipeline starvation.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic        pipe_regwrite;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_result;
  logic        pipe_stall;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_valid    (pipe_valid),
    .pipe_regwrite (pipe_regwrite),
    .pipe_rd       (pipe_rd),
    .pipe_result   (pipe_result),
    .pipe_stall    (pipe_stall),
    .mdu_valid     (mdu_valid),
    .mdu_rd        (mdu_rd),
    .mdu_result    (mdu_result),
    .mdu_ready     (mdu_ready),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wd         (rf_wd)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Advance one cycle; inputs are applied 1 unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid    = v;
    pipe_regwrite = v;
    pipe_rd       = rd;
    pipe_result   = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mdu_valid  = v;
    mdu_rd     = rd;
    mdu_result = d;
  endtask

  initial begin
    reset = 1'b1;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    #1;

    // Reset state
    step();
    step();
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_stall", 32'(pipe_stall), 32'd0);
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    reset = 1'b0;
    step();

    // Plain pipeline write
    set_pipe(1'b1, 5'd5, 32'hA5A5_0001);
    chk("p_stall", 32'(pipe_stall), 32'd0);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    chk("p_we", 32'(rf_we), 32'd1);
    chk("p_rd", 32'(rf_rd), 32'd5);
    chk("p_wd", rf_wd, 32'hA5A5_0001);
    step();
    chk("p_idle_we", 32'(rf_we), 32'd0);

    // MDU write with idle pipeline: accepted in N, granted N+1, visible N+2
    set_mdu(1'b1, 5'd7, 32'h1234);
    chk("m_ready0", 32'(mdu_ready), 32'd1);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk("m_ready1", 32'(mdu_ready), 32'd1);
    chk("m_we_n1", 32'(rf_we), 32'd0);
    step();
    chk("m_ready2", 32'(mdu_ready), 32'd1);
    chk("m_we_n2", 32'(rf_we), 32'd1);
    chk("m_rd_n2", 32'(rf_rd), 32'd7);
    chk("m_wd_n2", rf_wd, 32'h1234);
    step();
    chk("m_idle_we", 32'(rf_we), 32'd0);

    // Starvation: pipeline requests every cycle, MDU wins on the 5th contended cycle
    set_pipe(1'b1, 5'd3, 32'h30);
    set_mdu(1'b1, 5'd9, 32'h99);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("sv_stall_%0d", i), 32'(pipe_stall), (i == 5) ? 32'd1 : 32'd0);
      chk($sformatf("sv_rd_%0d", i), 32'(rf_rd), 32'd3);
      step();
    end
    chk("sv_mdu_rd", 32'(rf_rd), 32'd9);
    chk("sv_mdu_wd", rf_wd, 32'h99);
    chk("sv_after_stall", 32'(pipe_stall), 32'd0);
    step();
    chk("sv_pipe_lands", 32'(rf_rd), 32'd3);
    chk("sv_pipe_we", 32'(rf_we), 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();

    // Full buffer: refuses third offer, wins the port, order preserved
    set_pipe(1'b1, 5'd4, 32'h40);
    set_mdu(1'b1, 5'd1, 32'h11);
    chk("f_ready_a0", 32'(mdu_ready), 32'd1);
    chk("f_stall_a0", 32'(pipe_stall), 32'd0);
    step();
    set_mdu(1'b1, 5'd2, 32'h22);
    chk("f_ready_a1", 32'(mdu_ready), 32'd1);
    chk("f_stall_a1", 32'(pipe_stall), 32'd0);
    step();
    set_mdu(1'b1, 5'd3, 32'h33);
    chk("f_ready_a2", 32'(mdu_ready), 32'd0);
    chk("f_stall_a2", 32'(pipe_stall), 32'd1);
    chk("f_rd_a2", 32'(rf_rd), 32'd4);
    step();
    chk("f_rd_a3", 32'(rf_rd), 32'd1);
    chk("f_wd_a3", rf_wd, 32'h11);
    chk("f_ready_a3", 32'(mdu_ready), 32'd1);
    chk("f_stall_a3", 32'(pipe_stall), 32'd0);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk("f_rd_a4", 32'(rf_rd), 32'd4);
    chk("f_stall_a4", 32'(pipe_stall), 32'd1);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    chk("f_rd_a5", 32'(rf_rd), 32'd2);
    chk("f_wd_a5", rf_wd, 32'h22);
    step();
    chk("f_rd_a6", 32'(rf_rd), 32'd3);
    chk("f_wd_a6", rf_wd, 32'h33);
    step();
    chk("f_we_a7", 32'(rf_we), 32'd0);

    // x0 on both sides: nothing written, MDU offer accepted and discarded
    set_pipe(1'b1, 5'd0, 32'hBEEF);
    set_mdu(1'b1, 5'd0, 32'hDEAD);
    chk("z_ready", 32'(mdu_ready), 32'd1);
    chk("z_stall", 32'(pipe_stall), 32'd0);
    step();
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    chk("z_we0", 32'(rf_we), 32'd0);
    chk("z_count", 32'(dut.u_fifo.count), 32'd0);
    step();
    chk("z_we1", 32'(rf_we), 32'd0);

    // Reset with two entries buffered behind a busy pipeline
    set_pipe(1'b1, 5'd6, 32'h60);
    set_mdu(1'b1, 5'd10, 32'hA0);
    step();
    set_mdu(1'b1, 5'd11, 32'hB0);
    step();
    set_mdu(1'b0, 5'd0, 32'd0);
    chk("r_count_pre", 32'(dut.u_fifo.count), 32'd2);
    reset = 1'b1;
    #1;
    chk("r_ready_in_rst", 32'(mdu_ready), 32'd0);
    chk("r_stall_in_rst", 32'(pipe_stall), 32'd0);
    step();
    reset = 1'b0;
    set_pipe(1'b0, 5'd0, 32'd0);
    chk("r_count_post", 32'(dut.u_fifo.count), 32'd0);
    chk("r_we_post", 32'(rf_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("r_no_stale_%0d", i), 32'(rf_we), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
